// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-bank data memory arbiter.
// Contents:
//   NUM_REQ / NUM_BANK       requester and bank counts
//   REQ_CPU / REQ_CRYPT      requester indices
//   mem_req_t                one requester's access bundle, sized for the widest build
//   bank_of(addr, bit)       bank selected by a byte address
//   in_bank_addr(addr, bit)  word address inside a bank (byte-offset bits and bank bit removed)
package dmem_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int NUM_BANK   = 2;
  localparam int REQ_CPU    = 0;
  localparam int REQ_CRYPT  = 1;

  localparam int MAX_ADDR_W = 32;
  localparam int MAX_DATA_W = 64;

  typedef struct packed {
    logic                    we;
    logic [MAX_ADDR_W-1:0]   addr;
    logic [MAX_DATA_W-1:0]   wdata;
    logic [MAX_DATA_W/8-1:0] be;
  } mem_req_t;

  function automatic logic bank_of(input logic [MAX_ADDR_W-1:0] addr, input int bank_bit);
    return addr[bank_bit];
  endfunction

  // Packs every address bit from bit 2 upwards, skipping the bank-select bit,
  // into a dense in-bank word index. Callers truncate to their bank width.
  function automatic logic [MAX_ADDR_W-1:0] in_bank_addr(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int bank_bit);
    logic [MAX_ADDR_W-1:0] res;
    int                    k;
    res = '0;
    k   = 0;
    for (int i = 2; i < MAX_ADDR_W; i++) begin
      if (i != bank_bit) begin
        res[k] = addr[i];
        k++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_rr_picker.sv
// Two-way arbiter for one memory bank.
// Ports:
//   req_i       requests targeting this bank (index = requester)
//   ptr_i       requester that wins the next conflict
//   gnt_o       one-hot grant (or zero when idle)
//   conflict_o  both requesters want this bank this cycle
//   ptr_next_o  pointer value for the next cycle
module dmem_rr_picker
  import dmem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               conflict_o,
  output logic               ptr_next_o
);

  logic both;

  assign both       = &req_i;
  assign conflict_o = both;

  always_comb begin
    gnt_o      = req_i;
    ptr_next_o = ptr_i;
    if (both) begin
      if (FIXED_PRIO != 0) begin
        gnt_o = 2'b01;
      end else begin
        gnt_o      = ptr_i ? 2'b10 : 2'b01;
        // The loser of this conflict wins the next one.
        ptr_next_o = ~ptr_i;
      end
    end
  end

endmodule

// File: rtl/dmem_bank_arbiter.sv
// Shares the two data-memory banks between the CPU load/store port (requester 0)
// and the crypt engine memory port (requester 1). Each bank arbitrates on its own;
// conflicts are resolved round-robin (or CPU-first with FIXED_PRIO=1) and counted.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-low reset
//   req_i/we_i/addr_i/wdata_i/be_i  requester side, held until gnt_o
//   gnt_o                        combinational accept
//   rvalid_o/rdata_o             response one cycle after gnt_o (rdata 0 for writes)
//   bank_*_o                     per-bank access, driven in the grant cycle, zero when idle
//   bank_rdata_i                 bank read data, one cycle after bank_en_o
//   conflict_cnt_o               saturating conflict counter
module dmem_bank_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int BANK_BIT   = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ-1:0]                   we_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]       addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]       wdata_i,
  input  logic [NUM_REQ-1:0][DATA_W/8-1:0]     be_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  output logic [NUM_REQ-1:0]                   rvalid_o,
  output logic [NUM_REQ-1:0][DATA_W-1:0]       rdata_o,
  output logic [NUM_BANK-1:0]                  bank_en_o,
  output logic [NUM_BANK-1:0]                  bank_we_o,
  output logic [NUM_BANK-1:0][ADDR_W-4:0]      bank_addr_o,
  output logic [NUM_BANK-1:0][DATA_W-1:0]      bank_wdata_o,
  output logic [NUM_BANK-1:0][DATA_W/8-1:0]    bank_be_o,
  input  logic [NUM_BANK-1:0][DATA_W-1:0]      bank_rdata_i,
  output logic [15:0]                          conflict_cnt_o
);

  localparam int BA_W = ADDR_W - 3;

  logic [NUM_REQ-1:0]                 req_act;
  logic [NUM_REQ-1:0]                 tgt_bank;
  logic [NUM_REQ-1:0][BA_W-1:0]       word_addr;
  logic [NUM_BANK-1:0][NUM_REQ-1:0]   bank_req;
  logic [NUM_BANK-1:0][NUM_REQ-1:0]   bank_gnt;
  logic [NUM_BANK-1:0]                conflict;
  logic [NUM_BANK-1:0]                ptr_q, ptr_d;
  logic [NUM_REQ-1:0]                 rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0]                 rd_q, rd_d;
  logic [NUM_REQ-1:0]                 bsel_q, bsel_d;
  logic [15:0]                        cnt_q, cnt_d;
  logic [16:0]                        cnt_sum;

  // Requests are masked during reset so nothing reaches the banks.
  assign req_act = rst_i ? req_i : '0;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
    assign tgt_bank[r]  = bank_of(MAX_ADDR_W'(addr_i[r]), BANK_BIT);
    assign word_addr[r] = BA_W'(in_bank_addr(MAX_ADDR_W'(addr_i[r]), BANK_BIT));
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_bank_req
      assign bank_req[b][r] = req_act[r] & (tgt_bank[r] == 1'(b));
    end

    dmem_rr_picker #(
      .FIXED_PRIO (FIXED_PRIO)
    ) u_picker (
      .req_i      (bank_req[b]),
      .ptr_i      (ptr_q[b]),
      .gnt_o      (bank_gnt[b]),
      .conflict_o (conflict[b]),
      .ptr_next_o (ptr_d[b])
    );
  end

  // Grant cycle: route the winning requester onto its bank.
  always_comb begin
    bank_en_o    = '0;
    bank_we_o    = '0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    gnt_o        = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (bank_gnt[b][r]) begin
          bank_en_o[b]    = 1'b1;
          bank_we_o[b]    = we_i[r];
          bank_addr_o[b]  = word_addr[r];
          bank_wdata_o[b] = wdata_i[r];
          bank_be_o[b]    = be_i[r];
          gnt_o[r]        = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rvalid_d = gnt_o;
    rd_d     = gnt_o & ~we_i;
    bsel_d   = tgt_bank;
    cnt_sum  = {1'b0, cnt_q};
    for (int b = 0; b < NUM_BANK; b++) begin
      cnt_sum = cnt_sum + 17'(conflict[b]);
    end
    cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rvalid_q <= '0;
      rd_q     <= '0;
      bsel_q   <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rd_q     <= rd_d;
      bsel_q   <= bsel_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Response cycle: the bank's registered read data arrives now, so only the
  // routing is held in flops. Asserting reset drops any response in flight.
  assign rvalid_o = rvalid_q & {NUM_REQ{rst_i}};

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      rdata_o[r] = (rst_i && rd_q[r]) ? bank_rdata_i[bsel_q[r]] : '0;
    end
  end

  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_dmem_bank_arbiter.sv
// Bench for dmem_bank_arbiter: a round-robin instance (rr) and a fixed-priority
// instance (fp) each drive their own pair of behavioural banks. A flat word-addressed
// reference memory plus per-bank "who wins the next conflict" state predicts every
// grant, bank access, response and the conflict count.
module tb_dmem_bank_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [1:0]       req   [2];
  logic [1:0]       we    [2];
  logic [1:0][9:0]  addr  [2];
  logic [1:0][31:0] wdata [2];
  logic [1:0][3:0]  be    [2];

  logic [1:0]       gnt        [2];
  logic [1:0]       rvalid     [2];
  logic [1:0][31:0] rdata      [2];
  logic [1:0]       bank_en    [2];
  logic [1:0]       bank_we    [2];
  logic [1:0][6:0]  bank_addr  [2];
  logic [1:0][31:0] bank_wdata [2];
  logic [1:0][3:0]  bank_be    [2];
  logic [1:0][31:0] brd        [2];
  logic [15:0]      cnt        [2];

  dmem_bank_arbiter #(.ADDR_W(10), .DATA_W(32), .BANK_BIT(2), .FIXED_PRIO(0)) dut_rr (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .be_i(be[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .bank_en_o(bank_en[0]), .bank_we_o(bank_we[0]),
    .bank_addr_o(bank_addr[0]), .bank_wdata_o(bank_wdata[0]), .bank_be_o(bank_be[0]),
    .bank_rdata_i(brd[0]), .conflict_cnt_o(cnt[0])
  );

  dmem_bank_arbiter #(.ADDR_W(10), .DATA_W(32), .BANK_BIT(2), .FIXED_PRIO(1)) dut_fp (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .be_i(be[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .bank_en_o(bank_en[1]), .bank_we_o(bank_we[1]),
    .bank_addr_o(bank_addr[1]), .bank_wdata_o(bank_wdata[1]), .bank_be_o(bank_be[1]),
    .bank_rdata_i(brd[1]), .conflict_cnt_o(cnt[1])
  );

  function automatic logic [31:0] seed_word(input int k);
    return (32'(k) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Behavioural banks: registered read, byte-enabled write.
  logic [31:0] envm [2][2][128];
  logic        env_ready = 1'b0;

  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < 2; i++)
        for (int b = 0; b < 2; b++)
          for (int w = 0; w < 128; w++)
            envm[i][b][w] <= seed_word(2 * w + b);
      env_ready <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int b = 0; b < 2; b++) begin
          if (bank_en[i][b]) begin
            brd[i][b] <= envm[i][b][bank_addr[i][b]];
            if (bank_we[i][b])
              for (int k = 0; k < 4; k++)
                if (bank_be[i][b][k])
                  envm[i][b][bank_addr[i][b]][8*k +: 8] <= bank_wdata[i][b][8*k +: 8];
          end
        end
      end
    end
  end

  // Reference model state
  logic [31:0] refm     [2][256];
  logic        pref     [2][2];
  int          mcnt     [2];
  logic [1:0]  pend_vld [2];
  logic [31:0] pend_dat [2][2];
  logic [1:0]  mgnt     [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pref[i][0] = 1'b0;
      pref[i][1] = 1'b0;
      mcnt[i]    = 0;
      pend_vld[i] = 2'b00;
      pend_dat[i][0] = '0;
      pend_dat[i][1] = '0;
    end
  endtask

  task automatic model_inst(input int i);
    string            p;
    logic [1:0]       eg, e_en, e_we;
    logic [1:0][6:0]  e_ad;
    logic [1:0][31:0] e_wd;
    logic [1:0][3:0]  e_be;
    int               bk [2];
    int               word [2];
    int               nconf, win;
    logic             a0, a1;
    p = (i == 0) ? "rr" : "fp";
    eg = 0; e_en = 0; e_we = 0; e_ad = '0; e_wd = '0; e_be = '0; nconf = 0;
    for (int r = 0; r < 2; r++) begin
      word[r] = int'(addr[i][r]) / 4;
      bk[r]   = word[r] % 2;
    end
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        a0 = req[i][0] && (bk[0] == b);
        a1 = req[i][1] && (bk[1] == b);
        if (a0 && a1) begin
          win = (i == 1) ? 0 : int'(pref[i][b]);
          eg[win] = 1'b1;
          nconf++;
          pref[i][b] = (win == 0);
        end else if (a0) eg[0] = 1'b1;
        else if (a1)     eg[1] = 1'b1;
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (eg[r]) begin
        e_en[bk[r]] = 1'b1;
        e_we[bk[r]] = we[i][r];
        e_ad[bk[r]] = 7'(word[r] / 2);
        e_wd[bk[r]] = wdata[i][r];
        e_be[bk[r]] = be[i][r];
      end
    end
    check_eq({p, ".gnt"}, 64'(gnt[i]), 64'(eg));
    check_eq({p, ".bank_en"}, 64'(bank_en[i]), 64'(e_en));
    check_eq({p, ".bank_we"}, 64'(bank_we[i]), 64'(e_we));
    for (int b = 0; b < 2; b++) begin
      check_eq({p, ".bank_addr"}, 64'(bank_addr[i][b]), 64'(e_ad[b]));
      check_eq({p, ".bank_wdata"}, 64'(bank_wdata[i][b]), 64'(e_wd[b]));
      check_eq({p, ".bank_be"}, 64'(bank_be[i][b]), 64'(e_be[b]));
    end
    check_eq({p, ".rvalid"}, 64'(rvalid[i]), rst ? 64'(pend_vld[i]) : 64'd0);
    for (int r = 0; r < 2; r++)
      check_eq({p, ".rdata"}, 64'(rdata[i][r]),
               (rst && pend_vld[i][r]) ? 64'(pend_dat[i][r]) : 64'd0);
    check_eq({p, ".cnt"}, 64'(cnt[i]), 64'(mcnt[i]));
    // Advance model to the state after this clock edge.
    if (!rst) begin
      pref[i][0] = 1'b0; pref[i][1] = 1'b0;
      mcnt[i] = 0; pend_vld[i] = 2'b00;
      pend_dat[i][0] = '0; pend_dat[i][1] = '0;
    end else begin
      mcnt[i] = (mcnt[i] + nconf > 65535) ? 65535 : mcnt[i] + nconf;
      pend_vld[i] = eg;
      for (int r = 0; r < 2; r++)
        pend_dat[i][r] = (eg[r] && !we[i][r]) ? refm[i][word[r]] : 32'h0;
      for (int r = 0; r < 2; r++)
        if (eg[r] && we[i][r])
          for (int k = 0; k < 4; k++)
            if (be[i][r][k]) refm[i][word[r]][8*k +: 8] = wdata[i][r][8*k +: 8];
    end
    mgnt[i] = eg;
  endtask

  task automatic check_cycle();
    #1;
    model_inst(0);
    model_inst(1);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic rq, input logic w, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] e);
    for (int i = 0; i < 2; i++) begin
      req[i][r] = rq; we[i][r] = w; addr[i][r] = a; wdata[i][r] = d; be[i][r] = e;
    end
  endtask

  task automatic drive_random(input int i, input int r);
    if (mgnt[i][r] || !req[i][r]) begin
      req[i][r]   = ($urandom % 4) != 0;
      we[i][r]    = 1'($urandom % 2);
      addr[i][r]  = 10'($urandom % 128);
      wdata[i][r] = $urandom;
      be[i][r]    = 4'($urandom % 16);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 256; k++) refm[i][k] = seed_word(k);
      mgnt[i] = 2'b00;
    end
    model_reset();

    // Reset holds everything quiet even with both requesting.
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 10'h000, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 10'h000, 32'h0, 4'h0);
    tick();
    for (int c = 0; c < 2; c++) begin
      check_cycle();
      check_eq("rst.gnt", 64'(gnt[0]), 64'd0);
      check_eq("rst.bank_en", 64'(bank_en[0]), 64'd0);
      check_eq("rst.rvalid", 64'(rvalid[0]), 64'd0);
      check_eq("rst.cnt", 64'(cnt[0]), 64'd0);
      tick();
    end

    // Parallel: CPU writes bank 0, crypt reads bank 1.
    rst = 1'b1;
    set_req(0, 1'b1, 1'b1, 10'h000, 32'hDEADBEEF, 4'hF);
    set_req(1, 1'b1, 1'b0, 10'h004, 32'h0, 4'h0);
    check_cycle();
    check_eq("par.gnt", 64'(gnt[0]), 64'd3);
    check_eq("par.bank_en", 64'(bank_en[0]), 64'd3);
    tick();
    set_req(0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
    check_cycle();
    check_eq("par.rvalid", 64'(rvalid[0]), 64'd3);
    check_eq("par.rdata_cpu", 64'(rdata[0][0]), 64'd0);
    check_eq("par.rdata_crypt", 64'(rdata[0][1]), 64'(seed_word(1)));
    check_eq("par.cnt", 64'(cnt[0]), 64'd0);
    tick();

    // Conflict on bank 0 for four cycles.
    set_req(0, 1'b1, 1'b0, 10'h008, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
    for (int c = 0; c < 4; c++) begin
      check_cycle();
      check_eq("rr.seq", 64'(gnt[0]), (c % 2 == 0) ? 64'd1 : 64'd2);
      check_eq("fp.seq", 64'(gnt[1]), 64'd1);
      tick();
    end
    set_req(0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
    check_cycle();
    check_eq("rr.cnt4", 64'(cnt[0]), 64'd4);
    check_eq("fp.cnt4", 64'(cnt[1]), 64'd4);
    tick();

    // Reset mid-operation: CPU wins, pointer moves to crypt, then reset restores it.
    set_req(0, 1'b1, 1'b0, 10'h008, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
    check_cycle();
    check_eq("mid.gnt", 64'(gnt[0]), 64'd1);
    tick();
    rst = 1'b0;
    check_cycle();
    check_eq("mid.rvalid", 64'(rvalid[0]), 64'd0);
    tick();
    rst = 1'b1;
    check_cycle();
    check_eq("mid.after_rst", 64'(gnt[0]), 64'd1);
    tick();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 2500; c++) begin
      rst = ($urandom % 200) != 0;
      for (int i = 0; i < 2; i++)
        for (int r = 0; r < 2; r++) drive_random(i, r);
      check_cycle();
      tick();
    end

    // Counter saturation: continuous conflict on bank 0.
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 10'h030, 32'h0, 4'h0);
    for (int c = 0; c < 70000; c++) begin
      check_cycle();
      tick();
    end
    set_req(0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
    check_cycle();
    check_eq("sat.rr", 64'(cnt[0]), 64'hFFFF);
    check_eq("sat.fp", 64'(cnt[1]), 64'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
